wavepool_instr_queue: RTL and testbench
=======================================

# wavepool_instr_queue

Per-wavefront instruction buffer and round-robin selector that sits directly upstream of the wavepool-to-decode pipeline flops. It accepts fetched instructions tagged by wavefront ID and holds them in a small FIFO per wavefront slot. Each cycle it picks one eligible wavefront and presents that wavefront's oldest instruction, with its base registers, as a registered wave_* bundle to the flop stage feeding decode.

## Interface
- NUM_WF, 40, number of wavefront slots (wfid width fixed at 6)
- DEPTH, 2, FIFO entries per slot (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- buff_valid  in  1  fetched instruction write strobe
- buff_wfid  in  6  target slot of write
- buff_pc  in  32  PC of fetched instruction
- buff_instr  in  32  fetched instruction word
- dispatch_valid  in  1  new wavefront allocated to slot dispatch_wfid
- dispatch_wfid  in  6  slot being allocated
- dispatch_vgpr_base  in  10  VGPR base for slot
- dispatch_sgpr_base  in  9  SGPR base for slot
- dispatch_lds_base  in  16  LDS base for slot
- issue_ready  in  NUM_WF  per-slot "may send to decode" mask from issue
- flush_valid  in  1  discard all entries of flush_wfid (branch/halt)
- flush_wfid  in  6  slot to flush
- queue_full  out  NUM_WF  per-slot FIFO full flag to fetch
- queue_empty  out  NUM_WF  per-slot FIFO empty flag to fetch
- wave_instr_valid  out  1  registered; bundle below is valid
- wave_instr_pc  out  32  registered PC
- wave_instr  out  32  registered instruction word
- wave_wfid  out  6  registered slot ID
- wave_vgpr_base  out  10  registered VGPR base of slot
- wave_sgpr_base  out  9  registered SGPR base of slot
- wave_lds_base  out  16  registered LDS base of slot

## Operation
- Per slot: DEPTH-entry FIFO of {pc, instr}, rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits; base registers loaded on dispatch.
- Write: buff_valid with slot not full pushes entry. Write to full slot is dropped, state unchanged (fetch must honour queue_full). buff_wfid ≥ NUM_WF ignored.
- Eligible slot: count≠0, issue_ready bit set, not being flushed this cycle.
- Selection: round-robin; search starts at slot (last_grant+1) mod NUM_WF, wraps; first eligible wins. last_grant updates only on a grant. No eligible slot → wave_instr_valid=0 next cycle, other wave_* hold previous values.
- Grant pops head of that slot; head and slot bases registered onto wave_* outputs.
- Same-slot push and pop in one cycle: both happen, count unchanged; legal even when full (pop frees space first is NOT assumed: full-slot write still dropped).
- Flush: zeroes count and pointers of flush_wfid; simultaneous write to same slot is dropped; flush beats grant for that slot.
- Dispatch: loads bases and clears that slot's FIFO; simultaneous write to same slot is accepted after clear (count becomes 1). Dispatch and flush same slot: dispatch result with empty FIFO.
- queue_full/queue_empty are combinational from registered counts.

## Timing
- Reset (async, immediate): all counts/pointers 0, bases 0, last_grant=NUM_WF-1 (first search starts at slot 0), wave_instr_valid=0, all wave_* 0, queue_empty all 1, queue_full all 0.
- Write at edge N is eligible for selection in cycle N+1; appears on wave_* after edge N+1 earliest (1-cycle write-to-output latency).
- Throughput: one instruction per cycle across all slots; a single slot can be granted on consecutive cycles only if it is the sole eligible slot.
- issue_ready sampled combinationally in the selection cycle.
- Reset mid-operation discards all queued entries; no output glitch beyond async clear.

## Test plan
- Reset: assert rst mid-stream with 3 slots holding entries -> all wave_* 0, queue_empty all 1, no valid after release until new write.
- Single slot: dispatch slot 5 (vgpr 0x040, sgpr 0x020, lds 0x0100), write pc 0x100 instr 0xBF810000 -> next cycle wave_instr_valid=1, wfid 5, pc 0x100, bases as dispatched.
- Round-robin: slots 0,1,2 each hold 2 entries, all ready -> grant order 0,1,2,0,1,2 then valid=0.
- Full/drop: DEPTH=2, three writes to slot 3 without ready -> queue_full[3]=1, third dropped; raise ready -> exactly two instructions out in order.
- Flush race: slot 7 holds 2 entries, flush_wfid=7 with simultaneous write to 7 and ready -> no slot-7 output, queue_empty[7]=1.
- issue_ready gating: slots 2,4 loaded, ready only on 4 -> only slot 4 granted; enable 2 -> slot 2 granted next cycle.

Source files
------------

// File: rtl/wavepool_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : wavepool_instr_queue
// Brief    : Per-wavefront instruction FIFOs with a round-robin selector.
//            It presents the oldest instruction of the granted slot, together
//            with that slot's base registers, as a registered bundle to the
//            decode flop stage.
// Revision : 1.0 - initial release
// ============================================================================
module wavepool_instr_queue #(
    parameter int NUM_WF = 40,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buff_valid,
    input  logic [5:0]        buff_wfid,
    input  logic [31:0]       buff_pc,
    input  logic [31:0]       buff_instr,
    input  logic              dispatch_valid,
    input  logic [5:0]        dispatch_wfid,
    input  logic [9:0]        dispatch_vgpr_base,
    input  logic [8:0]        dispatch_sgpr_base,
    input  logic [15:0]       dispatch_lds_base,
    input  logic [NUM_WF-1:0] issue_ready,
    input  logic              flush_valid,
    input  logic [5:0]        flush_wfid,
    output logic [NUM_WF-1:0] queue_full,
    output logic [NUM_WF-1:0] queue_empty,
    output logic              wave_instr_valid,
    output logic [31:0]       wave_instr_pc,
    output logic [31:0]       wave_instr,
    output logic [5:0]        wave_wfid,
    output logic [9:0]        wave_vgpr_base,
    output logic [8:0]        wave_sgpr_base,
    output logic [15:0]       wave_lds_base
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [6:0]         c_NUM_WF    = 7'(NUM_WF);
    localparam logic [5:0]         c_LAST_INIT = 6'(NUM_WF - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);

    // Per-slot views gathered for the output mux
    logic [NUM_WF-1:0]       w_eligible;
    logic [NUM_WF-1:0][31:0] w_head_pc;
    logic [NUM_WF-1:0][31:0] w_head_instr;
    logic [NUM_WF-1:0][9:0]  w_vgpr;
    logic [NUM_WF-1:0][8:0]  w_sgpr;
    logic [NUM_WF-1:0][15:0] w_lds;

    logic       w_buff_in_range;
    logic       w_grant;
    logic [5:0] w_sel;
    logic [6:0] w_scan_idx;

    logic [5:0] r_last_grant;
    logic       r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [5:0]  r_wfid;
    logic [9:0]  r_vgpr;
    logic [8:0]  r_sgpr;
    logic [15:0] r_lds;

    // Writes aimed at a slot ID beyond the pool are ignored outright
    assign w_buff_in_range = buff_valid && ({1'b0, buff_wfid} < c_NUM_WF);

    for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_slot
        localparam logic [5:0] c_ID = 6'(gi);

        logic [31:0]        r_fifo_pc    [DEPTH];
        logic [31:0]        r_fifo_instr [DEPTH];
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_CNT_W-1:0] r_count;
        logic [9:0]         r_vgpr_base;
        logic [8:0]         r_sgpr_base;
        logic [15:0]        r_lds_base;

        logic               w_flush_hit;
        logic               w_disp_hit;
        logic               w_clear;
        logic               w_full;
        logic               w_push;
        logic               w_pop;
        logic [c_PTR_W-1:0] w_wr_addr;

        assign w_flush_hit = flush_valid && (flush_wfid == c_ID);
        assign w_disp_hit  = dispatch_valid && (dispatch_wfid == c_ID);
        assign w_clear     = w_flush_hit || w_disp_hit;
        assign w_full      = (r_count == c_DEPTH);

        // Flush kills a same-cycle write; dispatch clears first, so a write
        // riding along with it lands in the freshly emptied FIFO even if the
        // slot was full before. Pop never makes room for a same-cycle write.
        assign w_push = w_buff_in_range && (buff_wfid == c_ID) && !w_flush_hit
                        && (w_disp_hit || !w_full);
        assign w_pop  = w_grant && (w_sel == c_ID);

        assign w_wr_addr = w_clear ? '0 : r_wr_ptr;

        // A slot being cleared this cycle (flush or re-dispatch) is never
        // granted, so the popped entry and the bases it carries are coherent.
        assign w_eligible[gi] = (r_count != '0) && issue_ready[gi] && !w_clear;

        assign queue_full[gi]  = w_full;
        assign queue_empty[gi] = (r_count == '0);

        assign w_head_pc[gi]    = r_fifo_pc[r_rd_ptr];
        assign w_head_instr[gi] = r_fifo_instr[r_rd_ptr];
        assign w_vgpr[gi]       = r_vgpr_base;
        assign w_sgpr[gi]       = r_sgpr_base;
        assign w_lds[gi]        = r_lds_base;

        // FIFO payload storage; contents are qualified by the count
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_fifo_pc[w_wr_addr]    <= buff_pc;
                r_fifo_instr[w_wr_addr] <= buff_instr;
            end
        end

        // Pointer and occupancy bookkeeping
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_clear) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= w_push ? c_PTR_ONE : '0;
                r_count  <= w_push ? c_CNT_ONE : '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Base registers captured when a wavefront is allocated to the slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vgpr_base <= '0;
                r_sgpr_base <= '0;
                r_lds_base  <= '0;
            end else if (w_disp_hit) begin
                r_vgpr_base <= dispatch_vgpr_base;
                r_sgpr_base <= dispatch_sgpr_base;
                r_lds_base  <= dispatch_lds_base;
            end
        end
    end

    // Round-robin search starting one past the last granted slot, wrapping
    always_comb begin
        w_grant    = 1'b0;
        w_sel      = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NUM_WF; k++) begin
            w_scan_idx = {1'b0, r_last_grant} + 7'd1 + 7'(k);
            if (w_scan_idx >= c_NUM_WF) begin
                w_scan_idx = w_scan_idx - c_NUM_WF;
            end
            if (!w_grant && w_eligible[w_scan_idx[5:0]]) begin
                w_grant = 1'b1;
                w_sel   = w_scan_idx[5:0];
            end
        end
    end

    // Output bundle and round-robin pointer; payload holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_LAST_INIT;
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_instr      <= '0;
            r_wfid       <= '0;
            r_vgpr       <= '0;
            r_sgpr       <= '0;
            r_lds        <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_sel;
            r_valid      <= 1'b1;
            r_pc         <= w_head_pc[w_sel];
            r_instr      <= w_head_instr[w_sel];
            r_wfid       <= w_sel;
            r_vgpr       <= w_vgpr[w_sel];
            r_sgpr       <= w_sgpr[w_sel];
            r_lds        <= w_lds[w_sel];
        end else begin
            r_valid      <= 1'b0;
        end
    end

    assign wave_instr_valid = r_valid;
    assign wave_instr_pc    = r_pc;
    assign wave_instr       = r_instr;
    assign wave_wfid        = r_wfid;
    assign wave_vgpr_base   = r_vgpr;
    assign wave_sgpr_base   = r_sgpr;
    assign wave_lds_base    = r_lds;

endmodule
`default_nettype wire

// File: tb/tb_wavepool_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wavepool_instr_queue
// Brief    : Self-checking bench for wavepool_instr_queue. A queue-based model
//            predicts every output each cycle; directed scenarios add literal
//            expectations, then randomized traffic runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wavepool_instr_queue;

    localparam int NWF = 40;
    localparam int DEP = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            buff_valid = 1'b0;
    logic [5:0]      buff_wfid = '0;
    logic [31:0]     buff_pc = '0;
    logic [31:0]     buff_instr = '0;
    logic            dispatch_valid = 1'b0;
    logic [5:0]      dispatch_wfid = '0;
    logic [9:0]      dispatch_vgpr_base = '0;
    logic [8:0]      dispatch_sgpr_base = '0;
    logic [15:0]     dispatch_lds_base = '0;
    logic [NWF-1:0]  issue_ready = '0;
    logic            flush_valid = 1'b0;
    logic [5:0]      flush_wfid = '0;
    logic [NWF-1:0]  queue_full;
    logic [NWF-1:0]  queue_empty;
    logic            wave_instr_valid;
    logic [31:0]     wave_instr_pc;
    logic [31:0]     wave_instr;
    logic [5:0]      wave_wfid;
    logic [9:0]      wave_vgpr_base;
    logic [8:0]      wave_sgpr_base;
    logic [15:0]     wave_lds_base;

    wavepool_instr_queue #(.NUM_WF(NWF), .DEPTH(DEP)) dut (
        .clk                (clk),
        .rst                (rst),
        .buff_valid         (buff_valid),
        .buff_wfid          (buff_wfid),
        .buff_pc            (buff_pc),
        .buff_instr         (buff_instr),
        .dispatch_valid     (dispatch_valid),
        .dispatch_wfid      (dispatch_wfid),
        .dispatch_vgpr_base (dispatch_vgpr_base),
        .dispatch_sgpr_base (dispatch_sgpr_base),
        .dispatch_lds_base  (dispatch_lds_base),
        .issue_ready        (issue_ready),
        .flush_valid        (flush_valid),
        .flush_wfid         (flush_wfid),
        .queue_full         (queue_full),
        .queue_empty        (queue_empty),
        .wave_instr_valid   (wave_instr_valid),
        .wave_instr_pc      (wave_instr_pc),
        .wave_instr         (wave_instr),
        .wave_wfid          (wave_wfid),
        .wave_vgpr_base     (wave_vgpr_base),
        .wave_sgpr_base     (wave_sgpr_base),
        .wave_lds_base      (wave_lds_base)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: one queue of {pc, instr} per slot
    logic [63:0] mq [NWF][$];
    logic [9:0]  m_vgpr [NWF];
    logic [8:0]  m_sgpr [NWF];
    logic [15:0] m_lds  [NWF];
    int          m_last;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr;
    logic [5:0]  exp_wfid;
    logic [9:0]  exp_vgpr;
    logic [8:0]  exp_sgpr;
    logic [15:0] exp_lds;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NWF; i++) begin
            mq[i].delete();
            m_vgpr[i] = '0;
            m_sgpr[i] = '0;
            m_lds[i]  = '0;
        end
        m_last    = NWF - 1;
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_instr = '0;
        exp_wfid  = '0;
        exp_vgpr  = '0;
        exp_sgpr  = '0;
        exp_lds   = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int  g;
        int  w;
        bit  acc;
        g = -1;
        for (int k = 0; k < NWF; k++) begin
            int s;
            s = (m_last + 1 + k) % NWF;
            if (g < 0 && mq[s].size() != 0 && issue_ready[s]
                && !(flush_valid && int'(flush_wfid) == s)
                && !(dispatch_valid && int'(dispatch_wfid) == s))
                g = s;
        end
        w = int'(buff_wfid);
        acc = 1'b0;
        if (buff_valid && w < NWF && !(flush_valid && int'(flush_wfid) == w)) begin
            if (dispatch_valid && int'(dispatch_wfid) == w) acc = 1'b1;
            else if (mq[w].size() < DEP) acc = 1'b1;
        end
        if (g >= 0) begin
            exp_valid = 1'b1;
            exp_pc    = mq[g][0][63:32];
            exp_instr = mq[g][0][31:0];
            exp_wfid  = 6'(g);
            exp_vgpr  = m_vgpr[g];
            exp_sgpr  = m_sgpr[g];
            exp_lds   = m_lds[g];
            void'(mq[g].pop_front());
            m_last = g;
        end else begin
            exp_valid = 1'b0;
        end
        if (flush_valid && int'(flush_wfid) < NWF) mq[flush_wfid].delete();
        if (dispatch_valid && int'(dispatch_wfid) < NWF) begin
            mq[dispatch_wfid].delete();
            m_vgpr[dispatch_wfid] = dispatch_vgpr_base;
            m_sgpr[dispatch_wfid] = dispatch_sgpr_base;
            m_lds[dispatch_wfid]  = dispatch_lds_base;
        end
        if (acc) mq[w].push_back({buff_pc, buff_instr});
    endtask

    task automatic check_all();
        logic [NWF-1:0] ef, ee;
        for (int i = 0; i < NWF; i++) begin
            ef[i] = (mq[i].size() == DEP);
            ee[i] = (mq[i].size() == 0);
        end
        chk("valid", wave_instr_valid, exp_valid);
        chk("pc", wave_instr_pc, exp_pc);
        chk("instr", wave_instr, exp_instr);
        chk("wfid", wave_wfid, exp_wfid);
        chk("vgpr", wave_vgpr_base, exp_vgpr);
        chk("sgpr", wave_sgpr_base, exp_sgpr);
        chk("lds", wave_lds_base, exp_lds);
        chk("queue_full", queue_full, ef);
        chk("queue_empty", queue_empty, ee);
    endtask

    // One clock: predict, clock, compare on the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        buff_valid     = 1'b0;
        dispatch_valid = 1'b0;
        flush_valid    = 1'b0;
        issue_ready    = '0;
    endtask

    task automatic wr(input int w, input logic [31:0] pc, input logic [31:0] ins);
        buff_valid = 1'b1;
        buff_wfid  = 6'(w);
        buff_pc    = pc;
        buff_instr = ins;
        tick();
        buff_valid = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", wave_instr_valid, 1'b0);
        chk("rst_pc", wave_instr_pc, 32'h0);
        chk("rst_wfid", wave_wfid, 6'h0);
        chk("rst_bases", {wave_vgpr_base, wave_sgpr_base, wave_lds_base}, 35'h0);
        chk("rst_empty", queue_empty, {NWF{1'b1}});
        chk("rst_full", queue_full, {NWF{1'b0}});
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    function automatic logic [5:0] pick_slot();
        int v;
        v = $urandom_range(0, 11);
        return (v < 8) ? 6'(v) : 6'(28 + v);
    endfunction

    initial begin
        logic [63:0] r64;
        logic [5:0]  s;
        idle();
        @(negedge clk);
        do_reset();

        // Single slot with dispatched bases
        dispatch_valid = 1'b1; dispatch_wfid = 6'd5;
        dispatch_vgpr_base = 10'h040; dispatch_sgpr_base = 9'h020; dispatch_lds_base = 16'h0100;
        tick();
        dispatch_valid = 1'b0;
        issue_ready = {NWF{1'b1}};
        wr(5, 32'h100, 32'hBF810000);
        chk("single_lat", wave_instr_valid, 1'b0);
        tick();
        chk("single_valid", wave_instr_valid, 1'b1);
        chk("single_wfid", wave_wfid, 6'd5);
        chk("single_pc", wave_instr_pc, 32'h100);
        chk("single_instr", wave_instr, 32'hBF810000);
        chk("single_bases", {wave_vgpr_base, wave_sgpr_base, wave_lds_base},
            {10'h040, 9'h020, 16'h0100});

        // Round robin over slots 0,1,2 with two entries each
        issue_ready = '0;
        for (int k = 0; k < 6; k++) wr(k % 3, 32'h1000 + 32'(k), 32'(k));
        issue_ready = {NWF{1'b1}};
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_valid_%0d", k), wave_instr_valid, 1'b1);
            chk($sformatf("rr_wfid_%0d", k), wave_wfid, 6'(k % 3));
        end
        tick();
        chk("rr_drained", wave_instr_valid, 1'b0);

        // Full slot drops the third write
        issue_ready = '0;
        wr(3, 32'h300, 32'hA0);
        wr(3, 32'h304, 32'hA1);
        wr(3, 32'h308, 32'hA2);
        chk("full_flag3", queue_full[3], 1'b1);
        issue_ready[3] = 1'b1;
        tick();
        chk("full_out0", wave_instr_pc, 32'h300);
        tick();
        chk("full_out1", wave_instr_pc, 32'h304);
        tick();
        chk("full_done", wave_instr_valid, 1'b0);

        // Flush racing a write and readiness on slot 7
        issue_ready = '0;
        wr(7, 32'h700, 32'h1);
        wr(7, 32'h704, 32'h2);
        flush_valid = 1'b1; flush_wfid = 6'd7;
        buff_valid = 1'b1; buff_wfid = 6'd7; buff_pc = 32'h708;
        issue_ready = {NWF{1'b1}};
        tick();
        idle();
        chk("flush_noout", wave_instr_valid, 1'b0);
        chk("flush_empty7", queue_empty[7], 1'b1);
        issue_ready = {NWF{1'b1}};
        tick();
        chk("flush_noout2", wave_instr_valid, 1'b0);

        // issue_ready gating
        issue_ready = '0;
        wr(2, 32'h200, 32'h22);
        wr(4, 32'h400, 32'h44);
        issue_ready[4] = 1'b1;
        tick();
        chk("gate_wfid4", wave_wfid, 6'd4);
        issue_ready[2] = 1'b1;
        tick();
        chk("gate_valid2", wave_instr_valid, 1'b1);
        chk("gate_wfid2", wave_wfid, 6'd2);

        // Reset while three slots hold entries
        issue_ready = '0;
        wr(10, 32'hA00, 32'h0);
        wr(11, 32'hB00, 32'h0);
        wr(12, 32'hC00, 32'h0);
        do_reset();
        issue_ready = {NWF{1'b1}};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle", wave_instr_valid, 1'b0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            buff_valid = ($urandom_range(0, 99) < 60);
            buff_wfid  = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(40, 63)) : pick_slot();
            buff_pc    = $urandom;
            buff_instr = $urandom;
            r64 = {$urandom, $urandom};
            issue_ready = r64[NWF-1:0];
            flush_valid = ($urandom_range(0, 99) < 5);
            flush_wfid  = pick_slot();
            s = pick_slot();
            dispatch_valid = ($urandom_range(0, 99) < 5) && (mq[s].size() == 0);
            dispatch_wfid  = s;
            dispatch_vgpr_base = 10'($urandom);
            dispatch_sgpr_base = 9'($urandom);
            dispatch_lds_base  = 16'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
